// File: rtl/phase_sequencer.sv
// phase_sequencer: phase generator for the multi-cycle MIPS control unit.
// Steps through fetch/decode/execute/memory/writeback (P0..P4) according to
// the decoded instruction class, inserts memory wait states, skips P4 for sw,
// and parks in HALT on an illegal opcode, a memory timeout or a halt request.
// Instruction and cycle counters are kept for debug visibility.

module phase_sequencer #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic             mem_ready,
  input  logic [5:0]       op,
  input  logic [5:0]       irfunc,
  output logic [4:0]       p,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  // The wait counter only has to reach WAIT_MAX; a zero limit still needs one bit.
  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);
  localparam bit WAIT_EN = (WAIT_MAX > 0);

  // Opcode and function encodings of the supported instructions.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_P4   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE = 3'd0,
    CL_ADD  = 3'd1,
    CL_LW   = 3'd2,
    CL_SW   = 3'd3,
    CL_J    = 3'd4,
    CL_JAL  = 3'd5
  } iclass_t;

  state_t              state;
  state_t              next_state;
  iclass_t             iclass;
  iclass_t             dec_class;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_limit;
  logic                is_mem;
  logic                hold;
  logic                complete;
  logic                start;
  logic                set_illegal;
  logic                set_timeout;

  // Classify the instruction fields presented during decode.
  always_comb begin
    dec_class = CL_NONE;
    case (op)
      OP_RTYPE: begin
        if (irfunc == FN_ADD) begin
          dec_class = CL_ADD;
        end
      end
      OP_LW:   dec_class = CL_LW;
      OP_SW:   dec_class = CL_SW;
      OP_J:    dec_class = CL_J;
      OP_JAL:  dec_class = CL_JAL;
      default: dec_class = CL_NONE;
    endcase
  end

  assign is_mem     = (iclass == CL_LW) || (iclass == CL_SW);
  assign wait_limit = WAIT_EN && (wait_cnt == WAIT_LIM);

  // Next-state selection plus the one-cycle event strobes that drive the registers.
  always_comb begin
    next_state  = state;
    hold        = 1'b0;
    complete    = 1'b0;
    start       = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;

    case (state)
      ST_IDLE: begin
        if (run) begin
          next_state = ST_P0;
          start      = 1'b1;
        end
      end

      ST_P0: begin
        if (mem_ready) begin
          next_state = ST_P1;
        end else if (wait_limit) begin
          next_state  = ST_HALT;
          set_timeout = 1'b1;
        end else begin
          hold = 1'b1;
        end
      end

      ST_P1: begin
        if (dec_class == CL_NONE) begin
          next_state  = ST_HALT;
          set_illegal = 1'b1;
        end else begin
          next_state = ST_P2;
        end
      end

      ST_P2: begin
        next_state = ST_P3;
      end

      ST_P3: begin
        if (!is_mem) begin
          next_state = ST_P4;
        end else if (mem_ready) begin
          if (iclass == CL_SW) begin
            complete = 1'b1;
          end else begin
            next_state = ST_P4;
          end
        end else if (wait_limit) begin
          next_state  = ST_HALT;
          set_timeout = 1'b1;
        end else begin
          hold = 1'b1;
        end
      end

      ST_P4: begin
        complete = 1'b1;
      end

      ST_HALT: begin
        if (!run) begin
          next_state = ST_IDLE;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase

    if (complete) begin
      if (halt_req) begin
        next_state = ST_HALT;
      end else if (!run) begin
        next_state = ST_IDLE;
      end else begin
        next_state = ST_P0;
      end
    end
  end

  // Phase state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the instruction class as decode ends so later phases ignore op/irfunc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iclass <= CL_NONE;
    end else if (state == ST_P1) begin
      iclass <= dec_class;
    end
  end

  // Count held memory cycles; any phase change starts the count from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (hold) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky error flags, cleared only when a new run starts from IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else if (start) begin
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (set_illegal) begin
        illegal <= 1'b1;
      end
      if (set_timeout) begin
        timeout <= 1'b1;
      end
    end
  end

  // Completed-instruction counter, free-running with wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (complete) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Active-cycle counter: every edge spent in P0..P4, with wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (busy) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  // One-hot phase and status outputs decoded purely from the state register.
  always_comb begin
    p      = 5'b00000;
    busy   = 1'b0;
    halted = 1'b0;
    case (state)
      ST_P0:   begin p = 5'b00001; busy = 1'b1; end
      ST_P1:   begin p = 5'b00010; busy = 1'b1; end
      ST_P2:   begin p = 5'b00100; busy = 1'b1; end
      ST_P3:   begin p = 5'b01000; busy = 1'b1; end
      ST_P4:   begin p = 5'b10000; busy = 1'b1; end
      ST_HALT: halted = 1'b1;
      default: begin
        p      = 5'b00000;
        busy   = 1'b0;
        halted = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: drives whole instructions (class, memory wait lengths,
// run/halt_req at completion) and predicts the phase sequence per instruction.

module tb_phase_sequencer;

  localparam int CNT_W    = 16;
  localparam int WAIT_MAX = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             run;
  logic             halt_req;
  logic             mem_ready;
  logic [5:0]       op;
  logic [5:0]       irfunc;
  logic [4:0]       p;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;

  int total = 0;
  int bad   = 0;

  int   expInstr;
  int   expCycle;
  logic expIllegal;
  logic expTimeout;
  int   mode;

  phase_sequencer #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .halt_req    (halt_req),
    .mem_ready   (mem_ready),
    .op          (op),
    .irfunc      (irfunc),
    .p           (p),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .timeout     (timeout),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Instruction class from the opcode table: 0 add, 1 lw, 2 sw, 3 j, 4 jal, 5 unsupported.
  function automatic int classOf(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00 && f == 6'h20) return 0;
    if (o == 6'h23) return 1;
    if (o == 6'h2B) return 2;
    if (o == 6'h02) return 3;
    if (o == 6'h03) return 4;
    return 5;
  endfunction

  task automatic clockCycle(input logic [4:0] eP, input logic eH);
    checkOutput("p", p, eP);
    checkOutput("busy", busy, eP != 5'd0);
    checkOutput("halted", halted, eH);
    checkOutput("illegal", illegal, expIllegal);
    checkOutput("timeout", timeout, expTimeout);
    checkOutput("instr_count", instr_count, expInstr[CNT_W-1:0]);
    checkOutput("cycle_count", cycle_count, expCycle[CNT_W-1:0]);
    @(posedge clk);
    if (eP != 5'd0) expCycle++;
    @(negedge clk);
  endtask

  task automatic randMid();
    run      = 1'($urandom);
    halt_req = 1'($urandom);
  endtask

  // Bring the sequencer to the start of a fetch from wherever it was left.
  task automatic ensureRunning();
    if (mode == 2) begin
      run = 1'b1;
      halt_req = 1'($urandom);
      clockCycle(5'h00, 1'b1);
      run = 1'b0;
      clockCycle(5'h00, 1'b1);
      mode = 0;
    end
    if (mode == 0) begin
      if ($urandom_range(0, 3) == 0) begin
        run = 1'b0;
        clockCycle(5'h00, 1'b0);
      end
      run = 1'b1;
      halt_req = 1'($urandom);
      clockCycle(5'h00, 1'b0);
      expIllegal = 1'b0;
      expTimeout = 1'b0;
      mode = 1;
    end
  endtask

  // One instruction starting in P0: w0/w3 are wait cycles before mem_ready
  // (beyond WAIT_MAX means a timeout), runAfter/haltAfter apply at completion.
  task automatic applyStimulus(input logic [5:0] iop, input logic [5:0] ifn, input int w0,
                               input int w3, input logic runAfter, input logic haltAfter);
    int c;
    bit memAcc;
    c = classOf(iop, ifn);
    memAcc = (c == 1) || (c == 2);

    for (int i = 0; i <= w0; i++) begin
      op = 6'($urandom);
      irfunc = 6'($urandom);
      randMid();
      mem_ready = (i == w0);
      clockCycle(5'h01, 1'b0);
      if (i == w0) break;
      if (i == WAIT_MAX) begin
        expTimeout = 1'b1;
        mode = 2;
        return;
      end
    end

    op = iop;
    irfunc = ifn;
    mem_ready = 1'($urandom);
    randMid();
    clockCycle(5'h02, 1'b0);
    if (c == 5) begin
      expIllegal = 1'b1;
      mode = 2;
      return;
    end

    op = 6'($urandom);
    irfunc = 6'($urandom);
    mem_ready = 1'($urandom);
    randMid();
    clockCycle(5'h04, 1'b0);

    if (memAcc) begin
      for (int i = 0; i <= w3; i++) begin
        op = 6'($urandom);
        irfunc = 6'($urandom);
        mem_ready = (i == w3);
        if (i == w3 && c == 2) begin
          run = runAfter;
          halt_req = haltAfter;
        end else begin
          randMid();
        end
        clockCycle(5'h08, 1'b0);
        if (i == w3) break;
        if (i == WAIT_MAX) begin
          expTimeout = 1'b1;
          mode = 2;
          return;
        end
      end
    end else begin
      mem_ready = 1'($urandom);
      randMid();
      clockCycle(5'h08, 1'b0);
    end

    if (c != 2) begin
      mem_ready = 1'($urandom);
      run = runAfter;
      halt_req = haltAfter;
      clockCycle(5'h10, 1'b0);
    end

    expInstr++;
    if (haltAfter) mode = 2;
    else if (!runAfter) mode = 0;
    else mode = 1;
  endtask

  function automatic int pickWait();
    int x;
    x = $urandom_range(0, 15);
    if (x < 10) return 0;
    if (x < 13) return $urandom_range(1, 3);
    if (x == 13) return WAIT_MAX;
    if (x == 14) return WAIT_MAX - 1;
    return WAIT_MAX + 1;
  endfunction

  initial begin
    logic [5:0] rop;
    logic [5:0] rfn;
    int sel;

    run = 1'b0;
    halt_req = 1'b0;
    mem_ready = 1'b0;
    op = 6'h00;
    irfunc = 6'h00;
    expInstr = 0;
    expCycle = 0;
    expIllegal = 1'b0;
    expTimeout = 1'b0;
    mode = 0;

    #1 reset = 1'b0;
    #1;
    checkOutput("reset_p", p, 5'h00);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_halted", halted, 1'b0);
    checkOutput("reset_illegal", illegal, 1'b0);
    checkOutput("reset_timeout", timeout, 1'b0);
    checkOutput("reset_instr", instr_count, 0);
    checkOutput("reset_cycle", cycle_count, 0);
    @(negedge clk);
    reset = 1'b1;
    clockCycle(5'h00, 1'b0);

    ensureRunning();
    applyStimulus(6'h00, 6'h20, 0, 0, 1'b1, 1'b0);
    applyStimulus(6'h2B, 6'h11, 0, 3, 1'b1, 1'b0);
    applyStimulus(6'h23, 6'h05, 2, 0, 1'b1, 1'b0);
    applyStimulus(6'h3F, 6'h20, 0, 0, 1'b1, 1'b0);
    ensureRunning();
    applyStimulus(6'h00, 6'h21, 1, 0, 1'b1, 1'b0);
    ensureRunning();
    applyStimulus(6'h00, 6'h20, WAIT_MAX + 1, 0, 1'b1, 1'b0);
    ensureRunning();
    applyStimulus(6'h23, 6'h00, WAIT_MAX, WAIT_MAX, 1'b1, 1'b0);
    applyStimulus(6'h2B, 6'h00, 0, WAIT_MAX + 1, 1'b1, 1'b0);
    ensureRunning();
    applyStimulus(6'h03, 6'h00, 0, 0, 1'b1, 1'b1);
    ensureRunning();
    applyStimulus(6'h02, 6'h00, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      ensureRunning();
      sel = $urandom_range(0, 19);
      rfn = 6'($urandom);
      if (sel < 5 || sel == 19) begin
        rop = 6'h00;
        rfn = 6'h20;
      end else if (sel < 9) begin
        rop = 6'h23;
      end else if (sel < 13) begin
        rop = 6'h2B;
      end else if (sel < 15) begin
        rop = 6'h02;
      end else if (sel < 17) begin
        rop = 6'h03;
      end else if (sel == 17) begin
        rop = 6'h00;
        if (rfn == 6'h20) rfn = 6'h21;
      end else begin
        rop = 6'($urandom);
        while (classOf(rop, 6'h00) != 5) rop = rop + 6'd1;
      end
      applyStimulus(rop, rfn, pickWait(), pickWait(),
                    $urandom_range(0, 5) != 0, $urandom_range(0, 7) == 0);
    end

    ensureRunning();
    run = 1'b1;
    halt_req = 1'b0;
    mem_ready = 1'b1;
    clockCycle(5'h01, 1'b0);
    op = 6'h23;
    irfunc = 6'h00;
    clockCycle(5'h02, 1'b0);
    clockCycle(5'h04, 1'b0);
    mem_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_p", p, 5'h00);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_halted", halted, 1'b0);
    checkOutput("midrst_instr", instr_count, 0);
    checkOutput("midrst_cycle", cycle_count, 0);
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0;
    expInstr = 0;
    expCycle = 0;
    expIllegal = 1'b0;
    expTimeout = 1'b0;
    mode = 0;
    clockCycle(5'h00, 1'b0);
    ensureRunning();
    applyStimulus(6'h00, 6'h20, 0, 0, 1'b0, 1'b0);
    clockCycle(5'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
